// File: rtl/morse_pkg.sv
// Shared Morse definitions: FSM states, timing multipliers, element encoding
// and the character code table used by both the encoder and the decoder.
package morse_pkg;

    typedef enum logic [1:0] {
        IDLE,
        MARK,
        SPACE,
        STUCKW
    } state_t;

    localparam int DASH_MULT   = 2;
    localparam int LETTER_MULT = 2;
    localparam int WORD_MULT   = 5;
    localparam int STUCK_MULT  = 8;

    localparam logic DOT  = 1'b0;
    localparam logic DASH = 1'b1;

    localparam int LEN_W = 3;
    localparam int PAT_W = 7;

    // Pattern is right-justified in sending order: the first element is the
    // most significant of the len used bits.
    typedef struct packed {
        logic [LEN_W-1:0] len;
        logic [PAT_W-1:0] pat;
        logic [7:0]       ascii;
    } code_t;

    localparam int NUM_CODES = 51;

    localparam code_t CODE_TABLE [NUM_CODES] = '{
        {3'd2, 7'b0000001, 8'h41}, {3'd4, 7'b0001000, 8'h42}, {3'd4, 7'b0001010, 8'h43},
        {3'd3, 7'b0000100, 8'h44}, {3'd1, 7'b0000000, 8'h45}, {3'd4, 7'b0000010, 8'h46},
        {3'd3, 7'b0000110, 8'h47}, {3'd4, 7'b0000000, 8'h48}, {3'd2, 7'b0000000, 8'h49},
        {3'd4, 7'b0000111, 8'h4A}, {3'd3, 7'b0000101, 8'h4B}, {3'd4, 7'b0000100, 8'h4C},
        {3'd2, 7'b0000011, 8'h4D}, {3'd2, 7'b0000010, 8'h4E}, {3'd3, 7'b0000111, 8'h4F},
        {3'd4, 7'b0000110, 8'h50}, {3'd4, 7'b0001101, 8'h51}, {3'd3, 7'b0000010, 8'h52},
        {3'd3, 7'b0000000, 8'h53}, {3'd1, 7'b0000001, 8'h54}, {3'd3, 7'b0000001, 8'h55},
        {3'd4, 7'b0000001, 8'h56}, {3'd3, 7'b0000011, 8'h57}, {3'd4, 7'b0001001, 8'h58},
        {3'd4, 7'b0001011, 8'h59}, {3'd4, 7'b0001100, 8'h5A},
        {3'd5, 7'b0011111, 8'h30}, {3'd5, 7'b0001111, 8'h31}, {3'd5, 7'b0000111, 8'h32},
        {3'd5, 7'b0000011, 8'h33}, {3'd5, 7'b0000001, 8'h34}, {3'd5, 7'b0000000, 8'h35},
        {3'd5, 7'b0010000, 8'h36}, {3'd5, 7'b0011000, 8'h37}, {3'd5, 7'b0011100, 8'h38},
        {3'd5, 7'b0011110, 8'h39},
        {3'd6, 7'b0010101, 8'h2E}, {3'd6, 7'b0110011, 8'h2C}, {3'd6, 7'b0111000, 8'h3A},
        {3'd6, 7'b0101010, 8'h3B}, {3'd5, 7'b0010110, 8'h28}, {3'd6, 7'b0011110, 8'h27},
        {3'd6, 7'b0010010, 8'h22}, {3'd6, 7'b0100001, 8'h2D}, {3'd5, 7'b0010010, 8'h2F},
        {3'd6, 7'b0001101, 8'h5F}, {3'd6, 7'b0001100, 8'h3F}, {3'd6, 7'b0101011, 8'h21},
        {3'd5, 7'b0001010, 8'h2B}, {3'd6, 7'b0011010, 8'h40},
        {3'd6, 7'b0000101, 8'hFF}
    };

endpackage

// File: rtl/morse_lut.sv
// Combinational reverse lookup: element count and pattern to ASCII.
module morse_lut
    import morse_pkg::*;
(
    input  logic [LEN_W-1:0] count,
    input  logic [PAT_W-1:0] elems,
    output logic             hit,
    output logic [7:0]       ascii
);

    always_comb begin
        hit   = 1'b0;
        ascii = 8'h00;
        for (int i = 0; i < NUM_CODES; i++) begin
            if (!hit && CODE_TABLE[i].len == count && CODE_TABLE[i].pat == elems) begin
                hit   = 1'b1;
                ascii = CODE_TABLE[i].ascii;
            end
        end
    end

endmodule

// File: rtl/morse_rx_decoder.sv
// Morse receiver: times mark/space runs on a synchronised key line, assembles
// dot/dash elements and emits ASCII at letter gaps and 0x20 at word gaps.
module morse_rx_decoder
    import morse_pkg::*;
#(
    parameter int UNIT_CYCLES = 16,
    parameter int MAX_ELEM    = 7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_i,
    output logic [7:0] ascii_o,
    output logic       valid_o,
    output logic       err_o,
    output logic       busy_o,
    output state_t     state_dbg
);

    localparam int CNT_W = $clog2(STUCK_MULT * UNIT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] DASH_MIN   = CNT_W'(DASH_MULT * UNIT_CYCLES);
    localparam logic [CNT_W-1:0] LETTER_GAP = CNT_W'(LETTER_MULT * UNIT_CYCLES);
    localparam logic [CNT_W-1:0] WORD_GAP   = CNT_W'(WORD_MULT * UNIT_CYCLES);
    localparam logic [CNT_W-1:0] STUCK      = CNT_W'(STUCK_MULT * UNIT_CYCLES);
    localparam logic [CNT_W-1:0] GLITCH     = CNT_W'(UNIT_CYCLES / 4);
    localparam logic [LEN_W-1:0] MAX_CNT    = LEN_W'(MAX_ELEM);

    logic             s1, key_s;
    logic             rise, fall;
    logic [CNT_W-1:0] run, gap_base;
    logic             ctx_space;
    state_t           state, state_n;
    logic [PAT_W-1:0] elems;
    logic [LEN_W-1:0] count;
    logic             ovf, word_pending;
    logic             lut_hit;
    logic [7:0]       lut_ascii;
    logic             mark_start, glitch, append, elem, close_sym, word_end, stuck;

    function automatic logic [CNT_W-1:0] sat_sum(input logic [CNT_W-1:0] a,
                                                 input logic [CNT_W-1:0] b);
        logic [CNT_W:0] s;
        s = {1'b0, a} + {1'b0, b} + (CNT_W+1)'(1);
        return (s > {1'b0, STUCK}) ? STUCK : s[CNT_W-1:0];
    endfunction

    // Edges are taken one cycle early (stage 1 vs stage 2) so that every
    // decision and the run clear coincide with the key_s transition itself.
    assign rise = s1 & ~key_s;
    assign fall = ~s1 & key_s;

    morse_lut lut (
        .count (count),
        .elems (elems),
        .hit   (lut_hit),
        .ascii (lut_ascii)
    );

    always_comb begin
        state_n    = state;
        mark_start = 1'b0;
        glitch     = 1'b0;
        append     = 1'b0;
        elem       = DOT;
        close_sym  = 1'b0;
        word_end   = 1'b0;
        stuck      = 1'b0;
        case (state)
            IDLE: begin
                if (rise) begin
                    mark_start = 1'b1;
                    state_n    = MARK;
                end
            end
            MARK: begin
                if (run == STUCK) begin
                    stuck   = 1'b1;
                    state_n = STUCKW;
                end else if (fall) begin
                    if (run < GLITCH) begin
                        glitch  = 1'b1;
                        state_n = ctx_space ? SPACE : IDLE;
                    end else begin
                        append  = 1'b1;
                        elem    = (run >= DASH_MIN) ? DASH : DOT;
                        state_n = SPACE;
                    end
                end
            end
            SPACE: begin
                // Pending state is cleared by the event, so each fires once.
                close_sym = (run >= LETTER_GAP) && (count != '0 || ovf);
                word_end  = (run >= WORD_GAP) && word_pending;
                if (rise) begin
                    mark_start = 1'b1;
                    state_n    = MARK;
                end else if (word_end) begin
                    state_n = IDLE;
                end
            end
            STUCKW: begin
                if (!s1) state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1           <= 1'b0;
            key_s        <= 1'b0;
            run          <= '0;
            gap_base     <= '0;
            ctx_space    <= 1'b0;
            state        <= IDLE;
            elems        <= '0;
            count        <= '0;
            ovf          <= 1'b0;
            word_pending <= 1'b0;
            ascii_o      <= 8'h00;
            valid_o      <= 1'b0;
            err_o        <= 1'b0;
        end else begin
            s1      <= key_i;
            key_s   <= s1;
            state   <= state_n;
            valid_o <= 1'b0;
            err_o   <= 1'b0;

            // A glitch mark is folded back into the surrounding space run.
            if (glitch)
                run <= sat_sum(gap_base, run);
            else if (rise || fall)
                run <= '0;
            else if (run != STUCK)
                run <= run + CNT_W'(1);

            if (mark_start) begin
                gap_base  <= sat_sum(run, '0);
                ctx_space <= (state == SPACE);
            end

            if (append) begin
                if (count == MAX_CNT) begin
                    ovf <= 1'b1;
                end else begin
                    elems <= {elems[PAT_W-2:0], elem};
                    count <= count + LEN_W'(1);
                end
            end

            if (close_sym) begin
                if (ovf || !lut_hit) begin
                    err_o <= 1'b1;
                end else begin
                    ascii_o <= lut_ascii;
                    valid_o <= 1'b1;
                end
                elems        <= '0;
                count        <= '0;
                ovf          <= 1'b0;
                word_pending <= 1'b1;
            end

            if (word_end) begin
                ascii_o      <= 8'h20;
                valid_o      <= 1'b1;
                word_pending <= 1'b0;
            end

            if (stuck) begin
                err_o        <= 1'b1;
                elems        <= '0;
                count        <= '0;
                ovf          <= 1'b0;
                word_pending <= 1'b0;
            end
        end
    end

    assign busy_o    = (state == MARK) || (state == SPACE && (count != '0 || ovf));
    assign state_dbg = state;

endmodule

// File: tb/tb_morse_rx_decoder.sv
// Directed bench for morse_rx_decoder at UNIT_CYCLES=4: strobes are logged with
// their cycle number and compared against hand-computed event lists.
module tb_morse_rx_decoder;
    import morse_pkg::*;

    localparam int U  = 4;
    localparam int EW = 41;

    logic       clk = 1'b0;
    logic       rst;
    logic       key_i;
    logic [7:0] ascii_o;
    logic       valid_o;
    logic       err_o;
    logic       busy_o;
    state_t     state_dbg;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] cyc      = 0;

    // Event word: {is_err, ascii, cycle}
    logic [EW-1:0] obs_q[$];
    logic [EW-1:0] exp_q[$];

    string      code_str [6] = '{"...-.-", "-----", "..--..", "-...", ".-.-.-", "--..--"};
    logic [7:0] code_chr [6] = '{8'hFF, 8'h30, 8'h3F, 8'h42, 8'h2E, 8'h2C};

    morse_rx_decoder #(.UNIT_CYCLES(U), .MAX_ELEM(7)) dut (
        .clk       (clk),
        .rst       (rst),
        .key_i     (key_i),
        .ascii_o   (ascii_o),
        .valid_o   (valid_o),
        .err_o     (err_o),
        .busy_o    (busy_o),
        .state_dbg (state_dbg)
    );

    // ---------------- clock / reset / monitor ----------------
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 32'd1;

    always @(negedge clk) begin
        if (err_o)   obs_q.push_back({1'b1, 8'h00, cyc});
        if (valid_o) obs_q.push_back({1'b0, ascii_o, cyc});
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic send(input logic lvl, input int n);
        key_i = lvl;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_sym(input string s);
        for (int i = 0; i < s.len(); i++) begin
            send(1'b1, (s[i] == 8'h2d) ? 3 * U : U);
            if (i != s.len() - 1) send(1'b0, U);
        end
    endtask

    function automatic logic [EW-1:0] ev(input logic e, input logic [7:0] a, input logic [31:0] c);
        return {e, a, c};
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        rst   = 1'b1;
        key_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (ascii_o !== 8'h00) $display("FAIL rst_ascii: got %h want 00", ascii_o); else n_pass++;
        n_checks++; if (valid_o !== 1'b0) $display("FAIL rst_valid: got %b want 0", valid_o); else n_pass++;
        n_checks++; if (err_o !== 1'b0) $display("FAIL rst_err: got %b want 0", err_o); else n_pass++;
        n_checks++; if (busy_o !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy_o); else n_pass++;
        n_checks++; if (state_dbg !== IDLE) $display("FAIL rst_state: got %0d want %0d", state_dbg, IDLE); else n_pass++;
        rst = 1'b0;
        send(1'b0, 10);
    endtask

    task automatic test_letter_a();
        logic [31:0] t;
        obs_q.delete(); exp_q.delete();
        send_sym(".-");
        t = cyc;
        send(1'b0, 40);
        exp_q.push_back(ev(1'b0, 8'h41, t + 32'd11));
        exp_q.push_back(ev(1'b0, 8'h20, t + 32'd23));
        n_checks++;
        if (obs_q.size() !== exp_q.size()) $display("FAIL a_count: got %0d want %0d", obs_q.size(), exp_q.size()); else n_pass++;
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) $display("FAIL a_ev%0d: got %h want %h", i, obs_q[i], exp_q[i]); else n_pass++;
        end
        n_checks++; if (ascii_o !== 8'h20) $display("FAIL a_hold: got %h want 20", ascii_o); else n_pass++;
    endtask

    task automatic test_letter_gap();
        logic [31:0] t1, t2;
        obs_q.delete(); exp_q.delete();
        send_sym(".");
        t1 = cyc;
        send(1'b0, 3 * U);
        send_sym("-");
        t2 = cyc;
        send(1'b0, 40);
        exp_q.push_back(ev(1'b0, 8'h45, t1 + 32'd11));
        exp_q.push_back(ev(1'b0, 8'h54, t2 + 32'd11));
        exp_q.push_back(ev(1'b0, 8'h20, t2 + 32'd23));
        n_checks++;
        if (obs_q.size() !== exp_q.size()) $display("FAIL et_count: got %0d want %0d", obs_q.size(), exp_q.size()); else n_pass++;
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) $display("FAIL et_ev%0d: got %h want %h", i, obs_q[i], exp_q[i]); else n_pass++;
        end
    endtask

    task automatic test_word_gap();
        logic [31:0] t1, t2;
        obs_q.delete(); exp_q.delete();
        send_sym(".");
        t1 = cyc;
        send(1'b0, 6 * U);
        send_sym("-");
        t2 = cyc;
        send(1'b0, 40);
        exp_q.push_back(ev(1'b0, 8'h45, t1 + 32'd11));
        exp_q.push_back(ev(1'b0, 8'h20, t1 + 32'd23));
        exp_q.push_back(ev(1'b0, 8'h54, t2 + 32'd11));
        exp_q.push_back(ev(1'b0, 8'h20, t2 + 32'd23));
        n_checks++;
        if (obs_q.size() !== exp_q.size()) $display("FAIL e_t_count: got %0d want %0d", obs_q.size(), exp_q.size()); else n_pass++;
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) $display("FAIL e_t_ev%0d: got %h want %h", i, obs_q[i], exp_q[i]); else n_pass++;
        end
    endtask

    task automatic test_codes();
        logic [31:0] t;
        for (int k = 0; k < 6; k++) begin
            obs_q.delete(); exp_q.delete();
            send_sym(code_str[k]);
            t = cyc;
            send(1'b0, 40);
            exp_q.push_back(ev(1'b0, code_chr[k], t + 32'd11));
            exp_q.push_back(ev(1'b0, 8'h20, t + 32'd23));
            n_checks++;
            if (obs_q.size() !== exp_q.size()) $display("FAIL code%0d_count: got %0d want %0d", k, obs_q.size(), exp_q.size()); else n_pass++;
            for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
                n_checks++;
                if (obs_q[i] !== exp_q[i]) $display("FAIL code%0d_ev%0d: got %h want %h", k, i, obs_q[i], exp_q[i]); else n_pass++;
            end
        end
    endtask

    task automatic test_busy();
        send_sym(".");
        send(1'b0, 5);
        n_checks++; if (busy_o !== 1'b1) $display("FAIL busy_pending: got %b want 1", busy_o); else n_pass++;
        send(1'b0, 40);
        n_checks++; if (busy_o !== 1'b0) $display("FAIL busy_idle: got %b want 0", busy_o); else n_pass++;
        n_checks++; if (state_dbg !== IDLE) $display("FAIL busy_state: got %0d want %0d", state_dbg, IDLE); else n_pass++;
    endtask

    task automatic test_overflow();
        logic [31:0] t;
        obs_q.delete(); exp_q.delete();
        send_sym("........");
        t = cyc;
        send(1'b0, 40);
        exp_q.push_back(ev(1'b1, 8'h00, t + 32'd11));
        exp_q.push_back(ev(1'b0, 8'h20, t + 32'd23));
        n_checks++;
        if (obs_q.size() !== exp_q.size()) $display("FAIL ovf_count: got %0d want %0d", obs_q.size(), exp_q.size()); else n_pass++;
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) $display("FAIL ovf_ev%0d: got %h want %h", i, obs_q[i], exp_q[i]); else n_pass++;
        end
    endtask

    task automatic test_no_hit();
        logic [31:0] t;
        obs_q.delete(); exp_q.delete();
        send_sym("..--");
        t = cyc;
        send(1'b0, 40);
        exp_q.push_back(ev(1'b1, 8'h00, t + 32'd11));
        exp_q.push_back(ev(1'b0, 8'h20, t + 32'd23));
        n_checks++;
        if (obs_q.size() !== exp_q.size()) $display("FAIL nohit_count: got %0d want %0d", obs_q.size(), exp_q.size()); else n_pass++;
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) $display("FAIL nohit_ev%0d: got %h want %h", i, obs_q[i], exp_q[i]); else n_pass++;
        end
    endtask

    task automatic test_stuck();
        logic [31:0] t0, t;
        obs_q.delete(); exp_q.delete();
        t0 = cyc;
        send(1'b1, 40);
        send(1'b0, 60);
        send_sym(".");
        t = cyc;
        send(1'b0, 40);
        exp_q.push_back(ev(1'b1, 8'h00, t0 + 32'd35));
        exp_q.push_back(ev(1'b0, 8'h45, t + 32'd11));
        exp_q.push_back(ev(1'b0, 8'h20, t + 32'd23));
        n_checks++;
        if (obs_q.size() !== exp_q.size()) $display("FAIL stuck_count: got %0d want %0d", obs_q.size(), exp_q.size()); else n_pass++;
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) $display("FAIL stuck_ev%0d: got %h want %h", i, obs_q[i], exp_q[i]); else n_pass++;
        end
    endtask

    task automatic test_glitch();
        logic [31:0] t;
        obs_q.delete(); exp_q.delete();
        send(1'b1, 1);
        send(1'b0, 60);
        n_checks++;
        if (obs_q.size() !== 0) $display("FAIL glitch_idle: got %0d strobes want 0", obs_q.size()); else n_pass++;
        obs_q.delete();
        send_sym(".");
        t = cyc;
        send(1'b0, 3);
        send(1'b1, 1);
        send(1'b0, 40);
        exp_q.push_back(ev(1'b0, 8'h45, t + 32'd11));
        exp_q.push_back(ev(1'b0, 8'h20, t + 32'd23));
        n_checks++;
        if (obs_q.size() !== exp_q.size()) $display("FAIL glitch_gap_count: got %0d want %0d", obs_q.size(), exp_q.size()); else n_pass++;
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) $display("FAIL glitch_gap_ev%0d: got %h want %h", i, obs_q[i], exp_q[i]); else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] t;
        obs_q.delete(); exp_q.delete();
        send(1'b1, 6);
        rst   = 1'b1;
        key_i = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b0;
        send(1'b0, 40);
        n_checks++;
        if (obs_q.size() !== 0) $display("FAIL rstmid_count: got %0d strobes want 0", obs_q.size()); else n_pass++;
        n_checks++; if (ascii_o !== 8'h00) $display("FAIL rstmid_ascii: got %h want 00", ascii_o); else n_pass++;
        obs_q.delete();
        send_sym("-.");
        t = cyc;
        send(1'b0, 40);
        exp_q.push_back(ev(1'b0, 8'h4E, t + 32'd11));
        exp_q.push_back(ev(1'b0, 8'h20, t + 32'd23));
        n_checks++;
        if (obs_q.size() !== exp_q.size()) $display("FAIL rstmid_n_count: got %0d want %0d", obs_q.size(), exp_q.size()); else n_pass++;
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) $display("FAIL rstmid_n_ev%0d: got %h want %h", i, obs_q[i], exp_q[i]); else n_pass++;
        end
    endtask

    task automatic test_long_idle();
        logic [31:0] t;
        obs_q.delete(); exp_q.delete();
        send_sym(".");
        t = cyc;
        send(1'b0, 240);
        exp_q.push_back(ev(1'b0, 8'h45, t + 32'd11));
        exp_q.push_back(ev(1'b0, 8'h20, t + 32'd23));
        n_checks++;
        if (obs_q.size() !== exp_q.size()) $display("FAIL idle_count: got %0d want %0d", obs_q.size(), exp_q.size()); else n_pass++;
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) $display("FAIL idle_ev%0d: got %h want %h", i, obs_q[i], exp_q[i]); else n_pass++;
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_letter_a();
        test_letter_gap();
        test_word_gap();
        test_codes();
        test_busy();
        test_overflow();
        test_no_hit();
        test_stuck();
        test_glitch();
        test_reset_mid();
        test_long_idle();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
